// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO error-count readout path.
// Imported by the capture controller and its per-channel lanes.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } piso_state_e;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    localparam int DEFAULT_NCH   = 10;
    localparam int DEFAULT_WIDTH = 12;

endpackage

// File: rtl/piso_lane.sv
// One serial channel: drops the sampled q bit into the addressed position
// of a WIDTH-bit capture register while enabled.
module piso_lane #(
    parameter int WIDTH = 12,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] bit_idx,
    input  logic             q,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_r;

    // Capture register: one bit written per enabled cycle, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
        end else if (en) begin
            value_r[bit_idx] <= q;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/piso_multi_capture.sv
// Readout controller for the testchip PISO chains: sequences chip_load,
// deserialises NCH lanes and publishes whole frames with a valid pulse.
module piso_multi_capture
    import piso_pkg::*;
#(
    parameter int NCH       = DEFAULT_NCH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LOAD_CYC  = 2,
    parameter int MSB_FIRST = ORDER_LSB_FIRST,
    parameter int FCNT_W    = 16
) (
    input  logic                   shift_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [NCH-1:0]         q,
    output logic                   chip_load,
    output logic                   busy,
    output logic [NCH*WIDTH-1:0]   data,
    output logic                   data_valid,
    output logic [FCNT_W-1:0]      frame_cnt
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int LCNT_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_CYC - 1);

    piso_state_e           state_r;
    piso_state_e           state_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [LCNT_W-1:0]     load_cnt_r;
    logic [CNT_W-1:0]      bit_idx_s;
    logic                  shift_en_s;
    logic [NCH*WIDTH-1:0]  lane_bus_s;

    logic                  chip_load_r;
    logic                  busy_r;
    logic [NCH*WIDTH-1:0]  data_r;
    logic                  data_valid_r;
    logic [FCNT_W-1:0]     frame_cnt_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start || continuous) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (load_cnt_r == LOAD_LAST) begin
                    state_s = SHIFT;
                end else begin
                    state_s = LOAD;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Lane bit position for the current shift cycle
    always_comb begin
        bit_idx_s = bit_cnt_r;
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            bit_idx_s = BIT_LAST - bit_cnt_r;
        end else begin
            bit_idx_s = bit_cnt_r;
        end
    end

    assign shift_en_s = (state_r == SHIFT);

    // State, counters and registered outputs; outputs follow the next state
    // so chip_load is low for exactly the SHIFT cycles.
    always_ff @(posedge shift_clk) begin
        if (rst) begin
            state_r      <= IDLE;
            load_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            chip_load_r  <= 1'b1;
            busy_r       <= 1'b0;
            data_r       <= '0;
            data_valid_r <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == LOAD) && (load_cnt_r != LOAD_LAST)) begin
                load_cnt_r <= load_cnt_r + LCNT_W'(1);
            end else begin
                load_cnt_r <= '0;
            end
            if ((state_r == SHIFT) && (bit_cnt_r != BIT_LAST)) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= '0;
            end
            chip_load_r  <= (state_s != SHIFT);
            busy_r       <= (state_s != IDLE);
            data_valid_r <= (state_r == DONE);
            if (state_r == DONE) begin
                data_r      <= lane_bus_s;
                frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
            end else begin
                data_r      <= data_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        piso_lane #(
            .WIDTH (WIDTH),
            .IDX_W (CNT_W)
        ) u_lane (
            .clk     (shift_clk),
            .rst     (rst),
            .en      (shift_en_s),
            .bit_idx (bit_idx_s),
            .q       (q[g]),
            .value   (lane_bus_s[g*WIDTH +: WIDTH])
        );
    end

    assign chip_load  = chip_load_r;
    assign busy       = busy_r;
    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_piso_multi_capture.sv
// Bench for piso_multi_capture: a chip PISO model feeds three DUT variants
// (LSB-first, MSB-first, 2-bit frame counter) compared against a frame-level model.
module tb_piso_multi_capture;

    localparam int NCH = 10;
    localparam int W   = 12;
    localparam int L   = 2;
    localparam int F   = L + W + 1;

    logic shift_clk = 1'b0;
    always #5 shift_clk = ~shift_clk;

    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic [NCH-1:0] q;

    logic              cl_a, busy_a, dv_a, cl_b, busy_b, dv_b, cl_c, busy_c, dv_c;
    logic [NCH*W-1:0]  data_a, data_b, data_c;
    logic [15:0]       fc_a, fc_b;
    logic [1:0]        fc_c;

    piso_multi_capture #(.NCH(NCH), .WIDTH(W), .LOAD_CYC(L), .MSB_FIRST(0), .FCNT_W(16)) dut_a (
        .shift_clk(shift_clk), .rst(rst), .start(start), .continuous(continuous), .q(q),
        .chip_load(cl_a), .busy(busy_a), .data(data_a), .data_valid(dv_a), .frame_cnt(fc_a));
    piso_multi_capture #(.NCH(NCH), .WIDTH(W), .LOAD_CYC(L), .MSB_FIRST(1), .FCNT_W(16)) dut_b (
        .shift_clk(shift_clk), .rst(rst), .start(start), .continuous(continuous), .q(q),
        .chip_load(cl_b), .busy(busy_b), .data(data_b), .data_valid(dv_b), .frame_cnt(fc_b));
    piso_multi_capture #(.NCH(NCH), .WIDTH(W), .LOAD_CYC(L), .MSB_FIRST(0), .FCNT_W(2)) dut_c (
        .shift_clk(shift_clk), .rst(rst), .start(start), .continuous(continuous), .q(q),
        .chip_load(cl_c), .busy(busy_c), .data(data_c), .data_valid(dv_c), .frame_cnt(fc_c));

    // Chip-side PISO chains: parallel load while chip_load, shift LSB out otherwise
    logic [W-1:0] word [NCH];
    logic [W-1:0] sh   [NCH];
    always @(posedge shift_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (cl_a) sh[i] <= word[i];
            else      sh[i] <= sh[i] >> 1;
        end
    end
    always_comb begin
        q = '0;
        for (int i = 0; i < NCH; i++) q[i] = sh[i][0];
    end

    int checks = 0;
    int fails  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected frame contents straight from the words loaded into the chip
    function automatic logic [NCH*W-1:0] pack(input bit rev);
        logic [NCH*W-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++)
            for (int b = 0; b < W; b++)
                v[i*W + b] = rev ? word[i][W-1-b] : word[i][b];
        return v;
    endfunction

    // Frame-level model: position within a frame (-1 idle, 0..F-1 busy)
    int               m_pos = -1;
    logic             m_valid = 1'b0;
    logic [NCH*W-1:0] m_data = '0;
    logic [NCH*W-1:0] m_rev  = '0;
    logic [15:0]      m_fc   = '0;
    always @(posedge shift_clk) begin
        if (rst) begin
            m_pos <= -1; m_valid <= 1'b0; m_data <= '0; m_rev <= '0; m_fc <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_pos < 0) begin
                if (start || continuous) m_pos <= 0;
            end else if (m_pos < F - 1) begin
                m_pos <= m_pos + 1;
            end else begin
                m_valid <= 1'b1;
                m_fc    <= m_fc + 16'd1;
                m_data  <= pack(1'b0);
                m_rev   <= pack(1'b1);
                m_pos   <= continuous ? 0 : -1;
            end
        end
    end

    logic e_cl, e_busy;
    assign e_cl   = !((m_pos >= L) && (m_pos < L + W));
    assign e_busy = (m_pos >= 0);

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge shift_clk) begin
        if (chk_en) begin
            chk("chip_load_a", cl_a, e_cl);     chk("busy_a", busy_a, e_busy);
            chk("valid_a", dv_a, m_valid);      chk("data_a", data_a, m_data);
            chk("fcnt_a", fc_a, m_fc);
            chk("chip_load_b", cl_b, e_cl);     chk("busy_b", busy_b, e_busy);
            chk("valid_b", dv_b, m_valid);      chk("data_b", data_b, m_rev);
            chk("fcnt_b", fc_b, m_fc);
            chk("chip_load_c", cl_c, e_cl);     chk("busy_c", busy_c, e_busy);
            chk("valid_c", dv_c, m_valid);      chk("data_c", data_c, m_data);
            chk("fcnt_c", fc_c, m_fc[1:0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge shift_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        rst = 1'b0;
    endtask

    task automatic run_frame(output int lat, output int low);
        lat = 0; low = 0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            cyc(1);
            start = 1'b0;
            if (!cl_a) low++;
            if (dv_a) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat, low, k;
    int vt [3];
    logic [1:0] seq [5];

    initial begin
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        for (int i = 0; i < NCH; i++) word[i] = 12'h000;

        // Reset state
        do_reset();
        chk("rst_chip_load", cl_a, 1'b1); chk("rst_busy", busy_a, 1'b0);
        chk("rst_data", data_a, '0);      chk("rst_fcnt", fc_a, 16'd0);

        // 1: single LSB-first frame, latency and chip_load low window
        for (int i = 0; i < NCH; i++) word[i] = 12'h100 + 12'(i);
        run_frame(lat, low);
        chk("t1_latency", lat, 16);
        chk("t1_load_low", low, 12);
        chk("t1_ch0", data_a[11:0], 12'h100);
        chk("t1_ch9", data_a[119:108], 12'h109);
        chk("t1_fcnt", fc_a, 16'd1);

        // 2: bit order, same serial stream into both orders
        do_reset();
        for (int i = 0; i < NCH; i++) word[i] = 12'h3C0 + 12'(7 * i);
        word[0] = 12'h805;
        run_frame(lat, low);
        chk("t2_lsb_ch0", data_a[11:0], 12'h805);
        chk("t2_msb_ch0", data_b[11:0], 12'hA01);

        // 4: reset during the 6th SHIFT cycle aborts the frame
        do_reset();
        for (int i = 0; i < NCH; i++) word[i] = 12'h5A0 + 12'(i);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(7);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t4_chip_load", cl_a, 1'b1); chk("t4_busy", busy_a, 1'b0);
        chk("t4_data", data_a, '0);      chk("t4_fcnt", fc_a, 16'd0);
        chk("t4_valid", dv_a, 1'b0);
        for (int i = 0; i < NCH; i++) word[i] = 12'h0F0 + 12'(i);
        run_frame(lat, low);
        chk("t4_latency", lat, 16);
        chk("t4_ch1", data_a[23:12], 12'h0F1);
        chk("t4_fcnt_after", fc_a, 16'd1);

        // 5: start during SHIFT and DONE is ignored
        do_reset();
        for (int i = 0; i < NCH; i++) word[i] = 12'h700 + 12'(16 * i);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(9);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_valid", dv_a, 1'b1);
        cyc(20);
        chk("t5_fcnt", fc_a, 16'd1);
        chk("t5_busy", busy_a, 1'b0);

        // 3: continuous mode, dropped during frame 3's SHIFT
        do_reset();
        for (int i = 0; i < NCH; i++) word[i] = 12'h210 + 12'(i);
        continuous = 1'b1;
        k = 0;
        vt[0] = 0; vt[1] = 0; vt[2] = 0;
        for (int n = 1; n <= 80; n++) begin
            cyc(1);
            if (dv_a) begin
                vt[k] = n;
                k++;
                chk("t3_fcnt_at_valid", fc_a, 16'(k));
                for (int i = 0; i < NCH; i++) word[i] = word[i] + 12'h011;
            end
            if ((k == 2) && (n == vt[1] + 5)) continuous = 1'b0;
            if (k == 3) break;
        end
        chk("t3_frames", k, 3);
        chk("t3_first", vt[0], 16);
        chk("t3_gap1", vt[1] - vt[0], 15);
        chk("t3_gap2", vt[2] - vt[1], 15);
        cyc(5);
        chk("t3_idle", busy_a, 1'b0);
        chk("t3_fcnt_end", fc_a, 16'd3);

        // 6: 2-bit frame counter wraps
        do_reset();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < NCH; i++) word[i] = 12'h0A0 + 12'(f * 12'h111) + 12'(i);
            run_frame(lat, low);
            chk("t6_fcnt", fc_c, seq[f]);
            chk("t6_ch3", data_c[47:36], word[3]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
